serial_adder: RTL and testbench

Bit-serial ripple adder: the addition counterpart of the team's full-subtractor cells. It reuses a single full-adder cell across WIDTH clock cycles, LSB first, with a carry flip-flop between cycles. It sits beside the combinational gate-level arithmetic blocks as the area-minimal sequential adder for the FPGA lab designs. A start/busy/done handshake frames each operation.

---
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder. One full-adder cell is reused for
// WIDTH cycles (LSB first), with a carry flip-flop between steps.
// start/busy/done frame each operation; sum/cout hold until the next result.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must reach WIDTH without wrapping.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] acc_shift;

    // Full-adder step, next-state logic and result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        fa_s = a_q[0] ^ b_q[0] ^ carry_q;
        fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
        acc_shift            = acc_q >> 1;
        acc_shift[WIDTH-1]   = fa_s;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                carry_d = fa_c;
                acc_d   = acc_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Final step: publish result including this step's bit and carry.
                    sum_d   = acc_shift;
                    cout_d  = fa_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8, plus WIDTH=1 and WIDTH=32 instances.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=8 instance
    logic       st8, ci8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    // WIDTH=1 instance
    logic       st1, ci1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    // WIDTH=32 instance
    logic        st32, ci32, busy32, done32, cout32;
    logic [31:0] a32, b32, sum32;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .cin(ci1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );
    serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(st32), .a(a32), .b(b32), .cin(ci32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // WIDTH=8 operation with cycle-by-cycle checks; optional start poke during RUN.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic [7:0] es, input logic ec, input int poke, input string tag);
        @(negedge clk);
        a8 = av; b8 = bv; ci8 = ci; st8 = 1'b1;
        @(negedge clk);            // cycle 1
        st8 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            check({tag, " busy"}, 64'(busy8), 64'd1);
            check({tag, " done-early"}, 64'(done8), 64'd0);
            if (c == poke) begin
                st8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b1;
            end else begin
                st8 = 1'b0;
            end
        end
        @(negedge clk);            // cycle 9
        st8 = 1'b0;
        check({tag, " done"}, 64'(done8), 64'd1);
        check({tag, " busy-at-done"}, 64'(busy8), 64'd0);
        check({tag, " sum"}, 64'(sum8), 64'(es));
        check({tag, " cout"}, 64'(cout8), 64'(ec));
        @(negedge clk);            // cycle 10
        check({tag, " done-off"}, 64'(done8), 64'd0);
        check({tag, " sum-held"}, 64'(sum8), 64'(es));
    endtask

    task automatic op1(input logic av, input logic bv, input logic ci, input string tag);
        logic [1:0] exp;
        int n;
        exp = 2'(av) + 2'(bv) + 2'(ci);
        @(negedge clk);
        a1 = av; b1 = bv; ci1 = ci; st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        n = 1;
        while (done1 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd2);
        check({tag, " sum"}, 64'(sum1), 64'(exp[0]));
        check({tag, " cout"}, 64'(cout1), 64'(exp[1]));
    endtask

    task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic ci, input string tag);
        logic [32:0] exp;
        int n;
        exp = {1'b0, av} + {1'b0, bv} + 33'(ci);
        @(negedge clk);
        a32 = av; b32 = bv; ci32 = ci; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        n = 1;
        while (done32 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " sum"}, 64'(sum32), 64'(exp[31:0]));
        check({tag, " cout"}, 64'(cout32), 64'(exp[32]));
    endtask

    initial begin
        int pulses;
        rst = 1'b1;
        st8 = 0; a8 = '0; b8 = '0; ci8 = 0;
        st1 = 0; a1 = '0; b1 = '0; ci1 = 0;
        st32 = 0; a32 = '0; b32 = '0; ci32 = 0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst busy", 64'(busy8), 64'd0);
        check("rst done", 64'(done8), 64'd0);
        check("rst sum", 64'(sum8), 64'd0);
        check("rst cout", 64'(cout8), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic and carry-ripple adds
        op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 0, "basic");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "ripple1");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "ripple2");

        // start pulsed during RUN is ignored
        op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3, "ignstart");
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) pulses++;
        end
        check("ignstart no-second-op", 64'(pulses), 64'd0);

        // Reset mid-operation
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; st8 = 1'b1;
        @(negedge clk); st8 = 1'b0;    // cycle 1
        @(negedge clk);                // cycle 2
        @(negedge clk);                // cycle 3
        @(negedge clk); rst = 1'b1;    // cycle 4
        @(negedge clk);                // cycle 5
        check("midrst busy", 64'(busy8), 64'd0);
        check("midrst done", 64'(done8), 64'd0);
        check("midrst sum", 64'(sum8), 64'd0);
        check("midrst cout", 64'(cout8), 64'd0);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done8 === 1'b1) pulses++;
        end
        check("midrst no-done", 64'(pulses), 64'd0);
        op8(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 0, "postrst");

        // Back-to-back: start held high retriggers every 10 cycles
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; ci8 = 1'b1; st8 = 1'b1;   // cycle 0
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            check($sformatf("b2b done c%0d", c), 64'(done8), 64'((c % 10) == 9));
            if (c >= 9) check($sformatf("b2b sum c%0d", c), 64'(sum8), 64'h03);
        end
        @(negedge clk);                // cycle 30: drop start before it is sampled
        st8 = 1'b0;
        repeat (12) @(negedge clk);
        check("b2b stopped busy", 64'(busy8), 64'd0);

        // WIDTH=1 exhaustive
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            op1(vv[2], vv[1], vv[0], $sformatf("w1 v%0d", v));
        end

        // WIDTH=32 corners and random operands
        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "w32 wrap");
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "w32 max");
        op32(32'h1234_5678, 32'h8765_4321, 1'b0, "w32 dir");
        for (int r = 0; r < 4; r++) begin
            op32($urandom(), $urandom(), 1'($urandom_range(0, 1)), $sformatf("w32 rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
